// File: rtl/ifc_initiator.sv
// Host-side initiator for the en/rdy responder: in-order command FIFO feeding a
// one-command-at-a-time issue FSM, with read data returned on a valid/ready port.
// Optional rdy timeout abort is compiled in with `define IFC_INIT_TIMEOUT_EN.
module ifc_initiator #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_rdy,
  output logic              idle,
  output logic              err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            state_q, state_d;
  cmd_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  cmd_t              cur;
  logic              fifo_full, fifo_empty;
  logic              push, pop, rdy_sel, fire, tmo;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign cmd_ready  = !fifo_full && !RST;
  assign push       = cmd_valid && cmd_ready;

  // The selected rdy decides firing; RST kills both enables combinationally.
  assign rdy_sel  = cur.wr ? write_rdy : read_rdy;
  assign fire     = (state_q == S_ISSUE) && rdy_sel && !RST;
  assign write_en = fire && cur.wr;
  assign read_en  = fire && !cur.wr;

  assign write_address = cur.addr;
  assign read_address  = cur.addr;
  assign write_data    = cur.data;

  assign idle = fifo_empty && (state_q == S_IDLE) && !rsp_valid;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fire)     state_d = cur.wr ? S_IDLE : S_RESP;
        else if (tmo) state_d = S_IDLE;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= '{cmd_wr, cmd_addr, cmd_data};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cur       <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        cur.wr   <= fifo_mem[rd_ptr].wr;
        cur.addr <= fifo_mem[rd_ptr].addr;
        // Reads carry no payload; keep the last write data on the bus.
        if (fifo_mem[rd_ptr].wr) cur.data <= fifo_mem[rd_ptr].data;
      end
      if (read_en) begin
        rsp_valid <= 1'b1;
        rsp_addr  <= cur.addr;
        rsp_data  <= read_data;
      end else if (state_q == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef IFC_INIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // Abort on the cycle that would make the stall count reach TIMEOUT_CYC.
  assign tmo = (state_q == S_ISSUE) && !rdy_sel && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign err = err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo;
      if (pop)                                tmo_cnt <= '0;
      else if (state_q == S_ISSUE && !rdy_sel) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ifc_initiator.sv
// Bench for ifc_initiator: scenario tasks plus a randomized run scored against
// an in-order command model and a small memory responder.
module tb_ifc_initiator;
  logic       CLK = 1'b0;
  logic       RST;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [2:0] cmd_addr;
  logic       cmd_data;
  logic       rsp_valid, rsp_ready;
  logic [2:0] rsp_addr;
  logic       rsp_data;
  logic [2:0] write_address, read_address;
  logic       write_data, write_en, write_rdy;
  logic       read_en, read_data, read_rdy;
  logic       idle, err;

  always #5 CLK = ~CLK;

  ifc_initiator dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .write_address(write_address), .write_data(write_data), .write_en(write_en),
    .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy), .idle(idle), .err(err)
  );

  // Responder stub: 8 x 1 memory, read data combinational in the firing cycle
  logic mem [8] = '{default: 1'b0};
  assign read_data = mem[read_address];
  always @(posedge CLK) if (write_en) mem[write_address] <= write_data;

  logic model_mem [8] = '{default: 1'b0};

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int c; logic [2:0] a; logic d; } ev_t;
  ev_t wq[$];
  ev_t rq[$];
  int  err_cyc[$];
  int  rd_fires = 0;
  int  viol = 0;

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (write_en) wq.push_back('{cyc, write_address, write_data});
      if (read_en) rd_fires++;
      if (rsp_valid && rsp_ready) rq.push_back('{cyc, rsp_addr, rsp_data});
      if (err) err_cyc.push_back(cyc);
      if (write_en && read_en) viol++;
      if (write_en && !write_rdy) viol++;
      if (read_en && !read_rdy) viol++;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  bit rnd = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rnd) begin
      write_rdy = 1'($urandom_range(0, 1));
      read_rdy  = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic push(input logic wr, input logic [2:0] a, input logic d, output int t);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_data = d;
    while (cmd_ready !== 1'b1 && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL push_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    t = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < bound) begin tick(); n++; end
    n_cmp++;
    if (idle !== 1'b1) begin n_err++; $display("FAIL %s_idle: idle=%b, required 1", nm, idle); end
  endtask

  task automatic test_reset();
    RST = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_data = 0;
    write_rdy = 1; read_rdy = 1; rsp_ready = 1;
    tick(); tick();
    n_cmp++;
    if ({cmd_ready, write_en, read_en} !== 3'b000) begin
      n_err++; $display("FAIL reset_handshake: ready/wen/ren=%b, required 000", {cmd_ready, write_en, read_en});
    end
    n_cmp++;
    if ({rsp_valid, rsp_addr, rsp_data} !== 5'b0) begin
      n_err++; $display("FAIL reset_rsp: rsp v/a/d=%b, required 00000", {rsp_valid, rsp_addr, rsp_data});
    end
    n_cmp++;
    if ({write_address, read_address, write_data} !== 7'b0) begin
      n_err++; $display("FAIL reset_bus: wa/ra/wd=%b, required 0", {write_address, read_address, write_data});
    end
    n_cmp++;
    if ({idle, err} !== 2'b10) begin
      n_err++; $display("FAIL reset_idle_err: idle/err=%b, required 10", {idle, err});
    end
    RST = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    int t;
    wq.delete(); rq.delete();
    write_rdy = 1;
    push(1'b1, 3'd5, 1'b1, t);
    model_mem[5] = 1'b1;
    wait_idle(50, "single_write");
    n_cmp++;
    if (wq.size() !== 1) begin
      n_err++; $display("FAIL single_write_count: fires=%0d, required 1", wq.size());
    end else begin
      n_cmp++;
      if ({wq[0].a, wq[0].d} !== {3'd5, 1'b1}) begin
        n_err++; $display("FAIL single_write_bus: addr=%0d data=%b, required 5/1", wq[0].a, wq[0].d);
      end
      n_cmp++;
      if (wq[0].c !== t + 2) begin
        n_err++; $display("FAIL single_write_latency: fire cycle=%0d, required %0d", wq[0].c, t + 2);
      end
    end
    n_cmp++;
    if (rq.size() !== 0) begin n_err++; $display("FAIL single_write_norsp: rsp count=%0d, required 0", rq.size()); end
  endtask

  task automatic test_write_read();
    int t;
    wq.delete(); rq.delete();
    write_rdy = 1; read_rdy = 1; rsp_ready = 1;
    push(1'b1, 3'd3, 1'b1, t);
    model_mem[3] = 1'b1;
    push(1'b0, 3'd3, 1'b0, t);
    wait_idle(50, "write_read");
    n_cmp++;
    if (rq.size() !== 1) begin
      n_err++; $display("FAIL write_read_count: rsp count=%0d, required 1", rq.size());
    end else begin
      n_cmp++;
      if ({rq[0].a, rq[0].d} !== {3'd3, 1'b1}) begin
        n_err++; $display("FAIL write_read_rsp: addr=%0d data=%b, required 3/1", rq[0].a, rq[0].d);
      end
    end
    // Isolated read for the accept-to-response latency
    rq.delete();
    push(1'b0, 3'd5, 1'b0, t);
    wait_idle(50, "read_latency");
    n_cmp++;
    if (rq.size() !== 1) begin
      n_err++; $display("FAIL read_latency_count: rsp count=%0d, required 1", rq.size());
    end else begin
      n_cmp++;
      if (rq[0].c !== t + 3 || rq[0].d !== model_mem[5]) begin
        n_err++; $display("FAIL read_latency: cycle=%0d data=%b, required %0d/%b", rq[0].c, rq[0].d, t + 3, model_mem[5]);
      end
    end
  endtask

  task automatic test_fifo_full();
    int t;
    logic [2:0] ea [5];
    logic       ed [5];
    wq.delete();
    write_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      ea[i] = 3'($urandom_range(0, 7));
      ed[i] = 1'($urandom_range(0, 1));
      push(1'b1, ea[i], ed[i], t);
    end
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL fifo_full_ready: cmd_ready=%b, required 0", cmd_ready); end
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 3'd7; cmd_data = 1;
    tick(); tick(); tick();
    n_cmp++;
    if ({cmd_ready, idle, write_en} !== 3'b000 || wq.size() !== 0) begin
      n_err++; $display("FAIL fifo_full_stall: ready/idle/wen=%b fires=%0d, required 000/0", {cmd_ready, idle, write_en}, wq.size());
    end
    cmd_valid = 0;
    write_rdy = 1;
    for (int i = 0; i < 5; i++) model_mem[ea[i]] = ed[i];
    wait_idle(60, "fifo_full");
    n_cmp++;
    if (wq.size() !== 5) begin
      n_err++; $display("FAIL fifo_full_count: fires=%0d, required 5", wq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if ({wq[i].a, wq[i].d} !== {ea[i], ed[i]}) begin
          n_err++; $display("FAIL fifo_full_order[%0d]: addr=%0d data=%b, required %0d/%b", i, wq[i].a, wq[i].d, ea[i], ed[i]);
        end
        if (i > 0) begin
          n_cmp++;
          if (wq[i].c - wq[i-1].c !== 2) begin
            n_err++; $display("FAIL fifo_full_spacing[%0d]: gap=%0d, required 2", i, wq[i].c - wq[i-1].c);
          end
        end
      end
    end
  endtask

  task automatic test_rsp_backpressure();
    int t, base, n;
    logic [2:0] ra, wa, a0;
    logic       wd, d0, stable;
    wq.delete(); rq.delete();
    read_rdy = 1; write_rdy = 1; rsp_ready = 0;
    ra = 3'($urandom_range(0, 7)); wa = 3'($urandom_range(0, 7)); wd = 1'($urandom_range(0, 1));
    base = rd_fires;
    push(1'b0, ra, 1'b0, t);
    push(1'b1, wa, wd, t);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    a0 = rsp_addr; d0 = rsp_data;
    n_cmp++;
    if ({rsp_valid, a0, d0} !== {1'b1, ra, model_mem[ra]}) begin
      n_err++; $display("FAIL bp_rsp: v/addr/data=%b/%0d/%b, required 1/%0d/%b", rsp_valid, a0, d0, ra, model_mem[ra]);
    end
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_addr !== a0 || rsp_data !== d0 || read_en || write_en) stable = 0;
    end
    n_cmp++;
    if (stable !== 1'b1 || wq.size() !== 0 || rd_fires - base !== 1) begin
      n_err++; $display("FAIL bp_hold: stable=%b wfires=%0d rfires=%0d, required 1/0/1", stable, wq.size(), rd_fires - base);
    end
    model_mem[wa] = wd;
    rsp_ready = 1;
    wait_idle(30, "bp");
    n_cmp++;
    if (rq.size() !== 1 || wq.size() !== 1) begin
      n_err++; $display("FAIL bp_release_count: rsp=%0d wfires=%0d, required 1/1", rq.size(), wq.size());
    end else begin
      n_cmp++;
      if ({wq[0].a, wq[0].d} !== {wa, wd} || wq[0].c <= rq[0].c) begin
        n_err++; $display("FAIL bp_release_write: addr=%0d data=%b cyc=%0d rspcyc=%0d, required %0d/%b after rsp", wq[0].a, wq[0].d, wq[0].c, rq[0].c, wa, wd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    wq.delete(); rq.delete();
    write_rdy = 0;
    push(1'b1, 3'd2, 1'b1, t);
    push(1'b1, 3'd4, 1'b0, t);
    tick();
    RST = 1; write_rdy = 1; read_rdy = 1;
    #1;
    n_cmp++;
    if ({write_en, read_en, cmd_ready} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_force: wen/ren/ready=%b, required 000", {write_en, read_en, cmd_ready});
    end
    tick();
    RST = 0;
    #1;
    n_cmp++;
    if (idle !== 1'b1) begin n_err++; $display("FAIL rst_mid_idle: idle=%b, required 1", idle); end
    repeat (5) tick();
    n_cmp++;
    if (wq.size() !== 0) begin n_err++; $display("FAIL rst_mid_discard: write fires=%0d, required 0", wq.size()); end
    // Pending response must be dropped by reset
    rsp_ready = 0;
    push(1'b0, 3'd1, 1'b0, t);
    repeat (3) tick();
    n_cmp++;
    if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid_pending: rsp_valid=%b, required 1", rsp_valid); end
    RST = 1;
    tick();
    RST = 0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_addr, idle} !== 5'b00001) begin
      n_err++; $display("FAIL rst_mid_rsp_drop: v/addr/idle=%b, required 0/0/1", {rsp_valid, rsp_addr, idle});
    end
    rsp_ready = 1;
    repeat (4) tick();
    n_cmp++;
    if (rq.size() !== 0) begin n_err++; $display("FAIL rst_mid_norsp: rsp count=%0d, required 0", rq.size()); end
  endtask

  task automatic test_random();
    int t;
    logic       wr, d;
    logic [2:0] a;
    ev_t exp_w[$];
    ev_t exp_r[$];
    wq.delete(); rq.delete();
    rnd = 1;
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      d  = 1'($urandom_range(0, 1));
      if (wr) begin
        exp_w.push_back('{0, a, d});
        model_mem[a] = d;
      end else begin
        exp_r.push_back('{0, a, model_mem[a]});
      end
      push(wr, a, d, t);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle(2000, "random");
    rnd = 0; write_rdy = 1; read_rdy = 1; rsp_ready = 1;
    n_cmp++;
    if (wq.size() !== exp_w.size() || rq.size() !== exp_r.size()) begin
      n_err++; $display("FAIL random_counts: writes=%0d rsps=%0d, required %0d/%0d", wq.size(), rq.size(), exp_w.size(), exp_r.size());
    end else begin
      for (int i = 0; i < exp_w.size(); i++) begin
        n_cmp++;
        if ({wq[i].a, wq[i].d} !== {exp_w[i].a, exp_w[i].d}) begin
          n_err++; $display("FAIL random_write[%0d]: %0d/%b, required %0d/%b", i, wq[i].a, wq[i].d, exp_w[i].a, exp_w[i].d);
        end
      end
      for (int i = 0; i < exp_r.size(); i++) begin
        n_cmp++;
        if ({rq[i].a, rq[i].d} !== {exp_r[i].a, exp_r[i].d}) begin
          n_err++; $display("FAIL random_rsp[%0d]: %0d/%b, required %0d/%b", i, rq[i].a, rq[i].d, exp_r[i].a, exp_r[i].d);
        end
      end
    end
  endtask

  task automatic test_timeout();
`ifdef IFC_INIT_TIMEOUT_EN
    int t, n;
    err_cyc.delete(); rq.delete();
    read_rdy = 0; rsp_ready = 1;
    push(1'b0, 3'd6, 1'b0, t);
    n = 0;
    while (err_cyc.size() == 0 && n < 40) begin tick(); n++; end
    repeat (4) tick();
    n_cmp++;
    if (err_cyc.size() !== 1) begin
      n_err++; $display("FAIL timeout_pulses: err pulses=%0d, required 1", err_cyc.size());
    end else begin
      n_cmp++;
      if (err_cyc[0] !== t + 18) begin
        n_err++; $display("FAIL timeout_cycle: err cycle=%0d, required %0d", err_cyc[0], t + 18);
      end
    end
    n_cmp++;
    if (rq.size() !== 0 || idle !== 1'b1) begin
      n_err++; $display("FAIL timeout_after: rsps=%0d idle=%b, required 0/1", rq.size(), idle);
    end
    read_rdy = 1;
`else
    n_cmp++;
    if (err_cyc.size() !== 0) begin n_err++; $display("FAIL err_tied: err pulses=%0d, required 0", err_cyc.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_read();
    test_fifo_full();
    test_rsp_backpressure();
    test_reset_mid();
    test_random();
    test_timeout();
    n_cmp++;
    if (viol !== 0) begin n_err++; $display("FAIL enable_rules: violations=%0d, required 0", viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
